// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int PORT_IF = 0;
  localparam int PORT_LS = 1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: a lone requester wins, a tie
// goes to the port that did not win last time.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  // Pick the winner from the request pattern and the previous grant.
  always_comb begin
    valid = |req;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one shared
// memory command port. Each access holds the port for MEM_LATENCY cycles,
// writes on the last one, captures read data there and then pulses done for
// the winning port.
//
// Handshake: a port requests by holding req[p]; the request is sampled only in
// IDLE, the command is latched at the grant edge, and done[p] is a single-cycle
// completion pulse with rdata valid in that cycle. There is no backpressure.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 17,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2:0]            funct3_0,
  input  logic [2:0]            funct3_1,
  input  logic [DATA_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wd_0,
  input  logic [DATA_WIDTH-1:0] wd_1,
  output logic [1:0]            done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_we,
  output logic [2:0]            mem_funct3,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd,
  output logic [1:0]            dbg_state_o
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..15");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > DATA_WIDTH) begin : g_bad_addr_width
    $error("mem_arbiter: ADDR_WIDTH must be in 1..DATA_WIDTH");
  end

  localparam logic [CNT_W-1:0]      CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
  localparam logic [DATA_WIDTH-1:0] ADDR_MASK =
    {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - ADDR_WIDTH);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_q;
  logic                  win_q;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wd_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  grant;
  logic                  grant_valid;
  logic                  grant_now;
  logic                  final_access;
  logic [DATA_WIDTH-1:0] sel_addr;

  rr_arb2 u_rr_arb2 (
    .req   (req),
    .last  (last_q),
    .grant (grant),
    .valid (grant_valid)
  );

  assign grant_now    = (state_q == IDLE) && grant_valid;
  assign final_access = (state_q == ACCESS) && (cnt_q == '0);
  assign sel_addr     = (grant == 1'b1) ? addr_1 : addr_0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d = ACCESS;
          cnt_d   = CNT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: write strobe on the last access cycle only,
  // done pulse for the winner while in RESP.
  always_comb begin
    mem_we = final_access && we_q;
    done   = 2'b00;
    if (state_q == RESP) done[win_q] = 1'b1;
  end

  // Counter, command latches, last-grant and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (grant_now) begin
        last_q <= grant;
        win_q  <= grant;
        we_q   <= we[grant];
        f3_q   <= (grant == 1'b1) ? funct3_1 : funct3_0;
        addr_q <= sel_addr & ADDR_MASK;
        wd_q   <= (grant == 1'b1) ? wd_1 : wd_0;
      end
      if (final_access) rdata_q <= mem_rd;
    end
  end

  assign rdata       = rdata_q;
  assign mem_funct3  = f3_q;
  assign mem_addr    = addr_q;
  assign mem_wd      = wd_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of each memory word.
REQ-002 Parameter ADDR_WIDTH, default 17: number of significant byte-address bits forwarded to memory.
REQ-003 Parameter MEM_LATENCY, default 2: number of cycles the memory port is held per access; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  2  per-port request; bit 0 is instruction fetch, bit 1 is load/store.
REQ-007 we  input  2  per-port store enable, qualified by req.
REQ-008 funct3_0, funct3_1  input  3 each  per-port load/store type, passed through unchanged.
REQ-009 addr_0, addr_1  input  DATA_WIDTH each  per-port byte address.
REQ-010 wd_0, wd_1  input  DATA_WIDTH each  per-port store data.
REQ-011 done  output  2  one-cycle per-port completion pulse.
REQ-012 rdata  output  DATA_WIDTH  read data, valid while any done bit is high.
REQ-013 mem_we, mem_funct3, mem_addr, mem_wd  outputs  1/3/DATA_WIDTH/DATA_WIDTH  shared memory/cache command port.
REQ-014 mem_rd  input  DATA_WIDTH  combinational read data from the shared memory/cache.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-016 IDLE: if req is nonzero, the block SHALL select a winner, latch that port's we, funct3, addr and wd, load the counter with MEM_LATENCY-1 and enter ACCESS; if req is zero it SHALL stay in IDLE.
REQ-017 Arbitration: a single requester always wins; when both request, the port not granted most recently wins (round-robin).
REQ-018 The last-grant register SHALL update only when a grant is made.
REQ-019 ACCESS: mem_addr, mem_funct3 and mem_wd SHALL drive the latched values, with mem_addr zero-extended from its low ADDR_WIDTH bits.
REQ-020 ACCESS: the counter SHALL decrement each cycle and the FSM SHALL leave ACCESS on the cycle the counter reads 0.
REQ-021 mem_we SHALL be high only in the final ACCESS cycle (counter = 0) and only if the latched we is 1, giving exactly one write pulse per store.
REQ-022 In the final ACCESS cycle the block SHALL register mem_rd into rdata, then enter RESP.
REQ-023 RESP: done[winner] SHALL be high for exactly one cycle, after which the FSM returns to IDLE.
REQ-024 For stores, rdata SHALL hold the mem_rd value captured at the write edge.
REQ-025 Latency: with req sampled in IDLE at cycle 0, done SHALL be high in cycle MEM_LATENCY+1; peak throughput is one access per MEM_LATENCY+2 cycles.
REQ-026 Outside ACCESS, mem_we SHALL be 0 and mem_addr, mem_funct3 and mem_wd SHALL hold their last driven values.
REQ-027 Once granted, a transaction SHALL complete even if its req drops or its inputs change; latched values are used throughout.
REQ-028 A request on the other port during ACCESS or RESP SHALL wait and be arbitrated in the next IDLE cycle; no request is lost while req is held.
REQ-029 A requester still holding req in its done cycle is treated as a new request in the following IDLE cycle.
REQ-030 done SHALL never have both bits high, and rdata SHALL change only at the final-ACCESS capture edge.

Reset
REQ-031 While rst_n is low: state = IDLE, counter = 0, last-grant = port 1 (so port 0 wins the first tie), done = 0, rdata = 0, mem_we = 0, and mem_addr, mem_funct3 and mem_wd = 0.
REQ-032 Reset asserted mid-ACCESS SHALL force mem_we low immediately and abort the transaction with no done pulse; after release, only newly sampled requests are served.

Structure
REQ-033 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the port index constants (PORT_IF = 0, PORT_LS = 1) and the counter width (4 bits).
REQ-034 Sub-module rr_arb2 SHALL be the combinational 2-way round-robin picker: inputs req[1:0] and last, outputs grant and valid.
REQ-035 The counter, latches and FSM SHALL live in mem_arbiter.
REQ-036 An elaboration-time check SHALL reject any MEM_LATENCY outside 1..15.

Verification
REQ-037 Single load, MEM_LATENCY=2: req=01, addr_0=0x100, mem_rd=0xDEADBEEF -> done=01 in cycle 3 with rdata=0xDEADBEEF, and mem_we=0 throughout.
REQ-038 Single store: req=10, we=10, addr_1=0x204, wd_1=0x12345678 -> mem_we high for exactly one cycle (cycle 2) with mem_addr=0x204 and mem_wd=0x12345678, then done=10 in cycle 3.
REQ-039 Contention: req=11 held continuously from reset release -> grants alternate port 0, 1, 0, 1, with done pulses 4 cycles apart.
REQ-040 Drop mid-transaction: req_0 deasserted and addr_0 changed to 0x300 during ACCESS -> mem_addr stays 0x100 and done[0] still pulses.
REQ-041 Reset mid-store: rst_n pulled low in the first ACCESS cycle of a store -> mem_we never asserts, no done pulse, and all outputs read 0.
REQ-042 MEM_LATENCY=1: back-to-back requests on port 0 -> done every 3 cycles, with each rdata matching mem_rd at its capture edge.
